// File: rtl/step_counter.sv
// step_counter: parametrised step counter with up/down, enable, synchronous load,
// one-shot stop mode, and terminal-count and done flags.
// Optional build macro STEP_COUNTER_GRAY_OUT_EN: q presents the Gray code of the count.
module step_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned FIRST = 1,
    parameter int unsigned STEP  = 2,
    parameter int unsigned LIMIT = 15
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic             one_shot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             done
);

    // Largest on-grid value not above LIMIT.
    localparam int unsigned TOP = FIRST + STEP * ((LIMIT - FIRST) / STEP);

    localparam logic [WIDTH-1:0] TopW       = WIDTH'(TOP);
    localparam logic [WIDTH-1:0] FirstW     = WIDTH'(FIRST);
    localparam logic [WIDTH:0]   TopX       = (WIDTH + 1)'(TOP);
    localparam logic [WIDTH:0]   StepX      = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]   FirstStepX = (WIDTH + 1)'(FIRST + STEP);

    typedef enum logic [1:0] {StStart, StRun, StStop} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   sum_x;
    logic             wrap;

    // Extended arithmetic so the up-count overflow check cannot alias.
    always_comb begin
        cnt_x = {1'b0, cnt_q};
        sum_x = cnt_x + StepX;
        wrap  = up_dn ? (sum_x > TopX) : (cnt_x < FirstStepX);
    end

    // Next-state: load beats en beats hold; tc defaults low so it only pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        if (load) begin
            cnt_d   = (load_val > TopW) ? TopW : load_val;
            state_d = StRun;
            done_d  = 1'b0;
        end else if (en) begin
            unique case (state_q)
                StStart: begin
                    cnt_d   = FirstW;
                    state_d = StRun;
                end
                StRun: begin
                    if (wrap) begin
                        tc_d = 1'b1;
                        if (one_shot) begin
                            state_d = StStop;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = up_dn ? FirstW : TopW;
                        end
                    end else begin
                        cnt_d = up_dn ? sum_x[WIDTH-1:0] : (cnt_q - StepX[WIDTH-1:0]);
                    end
                end
                StStop: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = StStart;
                end
            endcase
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StStart;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

`ifdef STEP_COUNTER_GRAY_OUT_EN
    assign q = cnt_q ^ (cnt_q >> 1);
`else
    assign q = cnt_q;
`endif

    assign q_bar = ~q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule
